// File: rtl/regfile_sequencer.sv
// rtl/regfile_sequencer.sv - one-instruction-at-a-time read/execute/write sequencer for a 16x16 register file
module regfile_sequencer #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [19:0]       instr,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] result,
  output logic [ADDR_W-1:0] mem_raddr1,
  output logic [ADDR_W-1:0] mem_raddr2,
  input  logic [DATA_W-1:0] mem_rdata1,
  input  logic [DATA_W-1:0] mem_rdata2,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_waddr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_clr
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_EXEC,
    S_WRITE,
    S_DONE
  } state_t;

  localparam logic [2:0] OP_LOAD  = 3'd0;
  localparam logic [2:0] OP_ADD   = 3'd1;
  localparam logic [2:0] OP_ADDI  = 3'd2;
  localparam logic [2:0] OP_SUB   = 3'd3;
  localparam logic [2:0] OP_SUBI  = 3'd4;
  localparam logic [2:0] OP_MUL   = 3'd5;
  localparam logic [2:0] OP_CLEAR = 3'd6;
  localparam logic [2:0] OP_DISP  = 3'd7;

  state_t            state, state_n;
  logic [19:0]       instr_q;
  logic [DATA_W-1:0] op_a, op_b, alu_q, alu_n;

  logic [2:0]        op;
  logic [8:0]        fld;
  logic [DATA_W-1:0] sext_fld, sext_imm;

  assign op       = instr_q[19:17];
  assign fld      = instr_q[8:0];
  assign sext_fld = {{(DATA_W-9){fld[8]}}, fld};
  assign sext_imm = {{(DATA_W-13){instr_q[12]}}, instr_q[12:0]};

  // Addresses come straight from the latched instruction, so they hold outside READ.
  assign mem_raddr1 = instr_q[12:9];
  assign mem_raddr2 = instr_q[8:5];
  assign mem_waddr  = instr_q[16:13];
  assign mem_wdata  = alu_q;

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    busy    = 1'b1;
    done    = 1'b0;
    mem_we  = 1'b0;
    mem_clr = 1'b0;
    case (state)
      S_IDLE: begin
        busy = 1'b0;
        if (start) state_n = S_READ;
      end
      S_READ:  state_n = S_EXEC;
      S_EXEC:  state_n = S_WRITE;
      S_WRITE: begin
        // A reset landing on the write cycle must not disturb the register file.
        if (!rst) begin
          if (op == OP_CLEAR)     mem_clr = 1'b1;
          else if (op != OP_DISP) mem_we  = 1'b1;
        end
        state_n = S_DONE;
      end
      S_DONE: begin
        done    = 1'b1;
        state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_comb begin
    alu_n = '0;
    case (op)
      OP_LOAD:  alu_n = sext_imm;
      OP_ADD:   alu_n = op_a + op_b;
      OP_ADDI:  alu_n = op_a + sext_fld;
      OP_SUB:   alu_n = op_a - op_b;
      OP_SUBI:  alu_n = op_a - sext_fld;
      OP_MUL:   alu_n = op_a * op_b;
      OP_CLEAR: alu_n = '0;
      default:  alu_n = op_a;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      instr_q <= '0;
      op_a    <= '0;
      op_b    <= '0;
      alu_q   <= '0;
      result  <= '0;
    end else begin
      if (state == S_IDLE && start) instr_q <= instr;
      if (state == S_READ) begin
        op_a <= mem_rdata1;
        op_b <= mem_rdata2;
      end
      if (state == S_EXEC) alu_q <= alu_n;
      if (state == S_WRITE) result <= (op == OP_CLEAR) ? '0 : alu_q;
    end
  end

endmodule
